// File: rtl/maria_line_buffer_nbank_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maria_line_buffer_nbank_if : DMA write, playback and status bus of the line buffer
// Revision: 1.0
// ----------------------------------------------------------------------------
interface maria_line_buffer_nbank_if #(
  parameter int COL_W = 8
);
  logic             wr_en;
  logic [COL_W-1:0] wr_col;
  logic [2:0]       wr_pal;
  logic [7:0]       wr_pixels;
  logic             kangaroo;
  logic             swap;
  logic             rd_en;
  logic [COL_W-1:0] rd_col;
  logic [24:0][7:0] color_map;
  logic [7:0]       uv_out;
  logic [1:0]       wr_bank;
  logic             overrun;

  modport master (
    output wr_en, wr_col, wr_pal, wr_pixels, kangaroo, swap, rd_en, rd_col, color_map,
    input  uv_out, wr_bank, overrun
  );

  modport slave (
    input  wr_en, wr_col, wr_pal, wr_pixels, kangaroo, swap, rd_en, rd_col, color_map,
    output uv_out, wr_bank, overrun
  );
endinterface
`default_nettype wire

// File: rtl/maria_line_buffer_nbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// maria_line_buffer_nbank : N-bank rotating line buffer with clear-on-read playback.
// Optional MARIA_LBUF_COLLISION_EN adds the sticky sprite collision flag.
// Revision: 1.0
// ----------------------------------------------------------------------------
module maria_line_buffer_nbank #(
  parameter int NUM_BANKS = 2,
  parameter int LINE_W    = 160,
  parameter int COL_W     = 8
) (
  input  wire  sysclk,
  input  wire  reset_b,
`ifdef MARIA_LBUF_COLLISION_EN
  output logic collision,
`endif
  maria_line_buffer_nbank_if.slave bus
);

  localparam logic [1:0] LAST_BANK = 2'(NUM_BANKS - 1);

  typedef logic [4:0] entry_t;

  entry_t [NUM_BANKS-1:0][LINE_W-1:0] mem_q, mem_d;
  logic [1:0]       wr_bank_q, wr_bank_d, rd_bank;
  logic [7:0]       uv_q, uv_d;
  logic             overrun_q, overrun_d;
  entry_t           rd_entry;
  logic [4:0]       cidx;
  logic [COL_W-1:0] wcol [4];
  logic [1:0]       widx [4];
`ifdef MARIA_LBUF_COLLISION_EN
  logic             hit;
  logic             coll_q, coll_d;
`endif

  always_comb begin
    rd_bank   = (wr_bank_q == 2'd0) ? LAST_BANK : wr_bank_q - 2'd1;
    wr_bank_d = bus.swap ? ((wr_bank_q == LAST_BANK) ? 2'd0 : wr_bank_q + 2'd1) : wr_bank_q;
    overrun_d = overrun_q | (bus.wr_en & bus.swap);
  end

  // One byte covers four consecutive columns; [7:6] lands on the first one.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wcol[k] = bus.wr_col + COL_W'(k);
      widx[k] = bus.wr_pixels[7-2*k -: 2];
    end
  end

  // Write bank and display bank always differ, so the write and the clear never meet.
  always_comb begin
    mem_d    = mem_q;
    rd_entry = '0;
`ifdef MARIA_LBUF_COLLISION_EN
    hit      = 1'b0;
`endif
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int c = 0; c < LINE_W; c++) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.wr_en && (2'(b) == wr_bank_q) && (COL_W'(c) == wcol[k]) &&
              ((widx[k] != 2'd0) || bus.kangaroo)) begin
`ifdef MARIA_LBUF_COLLISION_EN
            if ((widx[k] != 2'd0) && (mem_q[b][c][1:0] != 2'd0)) hit = 1'b1;
`endif
            mem_d[b][c] = {bus.wr_pal, widx[k]};
          end
        end
        if (bus.rd_en && (2'(b) == rd_bank) && (COL_W'(c) == bus.rd_col)) begin
          rd_entry    = mem_q[b][c];
          mem_d[b][c] = '0;
        end
      end
    end
  end

  always_comb begin
    cidx = ({2'b00, rd_entry[4:2]} * 5'd3) + {3'b000, rd_entry[1:0]};
    uv_d = uv_q;
    if (bus.rd_en) begin
      uv_d = (rd_entry[1:0] == 2'd0) ? bus.color_map[0] : bus.color_map[cidx];
    end
  end

  always_ff @(posedge sysclk or negedge reset_b) begin
    if (!reset_b) begin
      mem_q     <= '0;
      wr_bank_q <= 2'd0;
      uv_q      <= 8'd0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_bank_q <= wr_bank_d;
      uv_q      <= uv_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.uv_out  = uv_q;
  assign bus.wr_bank = wr_bank_q;
  assign bus.overrun = overrun_q;

`ifdef MARIA_LBUF_COLLISION_EN
  // A collision in the swap cycle survives the swap's clear.
  always_comb coll_d = hit | (coll_q & ~bus.swap);

  always_ff @(posedge sysclk or negedge reset_b) begin
    if (!reset_b) coll_q <= 1'b0;
    else          coll_q <= coll_d;
  end

  assign collision = coll_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maria_line_buffer_nbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_maria_line_buffer_nbank : directed bench for the 2-bank and 3-bank line buffer.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_maria_line_buffer_nbank;

  logic             sysclk = 1'b0;
  logic             reset_b;
  logic [24:0][7:0] cmap;
  int               checks = 0;
  int               errors = 0;
`ifdef MARIA_LBUF_COLLISION_EN
  logic             coll2, coll3;
`endif

  always #5 sysclk = ~sysclk;

  maria_line_buffer_nbank_if #(.COL_W(8)) b2 ();
  maria_line_buffer_nbank_if #(.COL_W(8)) b3 ();

  assign b2.color_map = cmap;
  assign b3.color_map = cmap;

  maria_line_buffer_nbank #(.NUM_BANKS(2), .LINE_W(160), .COL_W(8)) dut2 (
    .sysclk    (sysclk),
    .reset_b   (reset_b),
`ifdef MARIA_LBUF_COLLISION_EN
    .collision (coll2),
`endif
    .bus       (b2)
  );

  maria_line_buffer_nbank #(.NUM_BANKS(3), .LINE_W(160), .COL_W(8)) dut3 (
    .sysclk    (sysclk),
    .reset_b   (reset_b),
`ifdef MARIA_LBUF_COLLISION_EN
    .collision (coll3),
`endif
    .bus       (b3)
  );

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic wr2(input logic [7:0] col, input logic [2:0] pal, input logic [7:0] pix,
                     input logic kang, input logic swp);
    b2.wr_en = 1'b1; b2.wr_col = col; b2.wr_pal = pal; b2.wr_pixels = pix;
    b2.kangaroo = kang; b2.swap = swp;
    step();
    b2.wr_en = 1'b0; b2.kangaroo = 1'b0; b2.swap = 1'b0;
  endtask

  task automatic swap2();
    b2.swap = 1'b1;
    step();
    b2.swap = 1'b0;
  endtask

  task automatic rd2(input logic [7:0] col);
    b2.rd_en = 1'b1; b2.rd_col = col;
    step();
    b2.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (b2.uv_out !== 8'h00) begin errors++; $display("FAIL reset_uv: got %h exp %h", b2.uv_out, 8'h00); end
    checks++; if (b2.wr_bank !== 2'd0) begin errors++; $display("FAIL reset_wr_bank: got %0d exp 0", b2.wr_bank); end
    checks++; if (b2.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", b2.overrun); end
    checks++; if (b3.wr_bank !== 2'd0) begin errors++; $display("FAIL reset_wr_bank3: got %0d exp 0", b3.wr_bank); end
    @(negedge sysclk);
    reset_b = 1'b1;
    b2.rd_en = 1'b1; b2.rd_col = 8'd0;
    #1;
    checks++; if (b2.uv_out !== 8'h00) begin errors++; $display("FAIL read_latency_pre: got %h exp %h", b2.uv_out, 8'h00); end
    step();
    b2.rd_en = 1'b0;
    checks++; if (b2.uv_out !== 8'h80) begin errors++; $display("FAIL read_latency_post: got %h exp %h", b2.uv_out, 8'h80); end
    for (int c = 1; c < 160; c++) begin
      rd2(8'(c));
      checks++; if (b2.uv_out !== 8'h80) begin errors++; $display("FAIL reset_bg col%0d: got %h exp %h", c, b2.uv_out, 8'h80); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] cols [4];
    logic [7:0] exp  [4];
    cols[0] = 8'd10; cols[1] = 8'd11; cols[2] = 8'd13; cols[3] = 8'd12;
    exp[0]  = 8'h87; exp[1]  = 8'h4A; exp[2]  = 8'h80; exp[3]  = 8'h89;
    wr2(8'd10, 3'd2, 8'h6C, 1'b0, 1'b0);
    swap2();
    checks++; if (b2.wr_bank !== 2'd1) begin errors++; $display("FAIL swap_wr_bank: got %0d exp 1", b2.wr_bank); end
    for (int i = 0; i < 4; i++) begin
      rd2(cols[i]);
      checks++; if (b2.uv_out !== exp[i]) begin errors++; $display("FAIL wr_rd col%0d: got %h exp %h", cols[i], b2.uv_out, exp[i]); end
    end
    step();
    checks++; if (b2.uv_out !== 8'h89) begin errors++; $display("FAIL uv_hold: got %h exp %h", b2.uv_out, 8'h89); end
    for (int i = 0; i < 4; i++) begin
      rd2(cols[i]);
      checks++; if (b2.uv_out !== 8'h80) begin errors++; $display("FAIL cleared col%0d: got %h exp %h", cols[i], b2.uv_out, 8'h80); end
    end
  endtask

  task automatic test_kangaroo();
    logic [7:0] exp [4];
    // Bank 1: prior pal 1 idx 3 at col 13, then opaque overwrite with pixel 0.
    wr2(8'd13, 3'd1, 8'hC0, 1'b0, 1'b0);
    wr2(8'd10, 3'd2, 8'h6C, 1'b1, 1'b0);
    swap2();
    exp[0] = 8'h87; exp[1] = 8'h4A; exp[2] = 8'h89; exp[3] = 8'h80;
    for (int i = 0; i < 4; i++) begin
      rd2(8'(10 + i));
      checks++; if (b2.uv_out !== exp[i]) begin errors++; $display("FAIL kangaroo1 col%0d: got %h exp %h", 10 + i, b2.uv_out, exp[i]); end
    end
    wr2(8'd13, 3'd1, 8'hC0, 1'b0, 1'b0);
    wr2(8'd10, 3'd2, 8'h6C, 1'b0, 1'b0);
    swap2();
    exp[3] = 8'h86;
    for (int i = 0; i < 4; i++) begin
      rd2(8'(10 + i));
      checks++; if (b2.uv_out !== exp[i]) begin errors++; $display("FAIL kangaroo0 col%0d: got %h exp %h", 10 + i, b2.uv_out, exp[i]); end
    end
  endtask

  task automatic test_clip();
    logic [7:0] cols [7];
    logic [7:0] exp  [7];
    cols[0] = 8'd0;   cols[1] = 8'd1;   cols[2] = 8'd2;   cols[3] = 8'd158;
    cols[4] = 8'd159; cols[5] = 8'd160; cols[6] = 8'd254;
    exp[0]  = 8'h8F;  exp[1]  = 8'h8F;  exp[2]  = 8'h80;  exp[3]  = 8'h8C;
    exp[4]  = 8'h8C;  exp[5]  = 8'h80;  exp[6]  = 8'h80;
    wr2(8'd158, 3'd3, 8'hFF, 1'b0, 1'b0);
    wr2(8'd254, 3'd4, 8'hFF, 1'b0, 1'b0);
    swap2();
    for (int i = 0; i < 7; i++) begin
      rd2(cols[i]);
      checks++; if (b2.uv_out !== exp[i]) begin errors++; $display("FAIL clip col%0d: got %h exp %h", cols[i], b2.uv_out, exp[i]); end
    end
  endtask

  task automatic test_read_swap();
    wr2(8'd20, 3'd5, 8'h40, 1'b0, 1'b0);
    swap2();
    b2.rd_en = 1'b1; b2.rd_col = 8'd20; b2.swap = 1'b1;
    step();
    b2.rd_en = 1'b0; b2.swap = 1'b0;
    checks++; if (b2.uv_out !== 8'h90) begin errors++; $display("FAIL read_swap_data: got %h exp %h", b2.uv_out, 8'h90); end
    checks++; if (b2.wr_bank !== 2'd0) begin errors++; $display("FAIL read_swap_bank: got %0d exp 0", b2.wr_bank); end
    swap2();
    rd2(8'd20);
    checks++; if (b2.uv_out !== 8'h80) begin errors++; $display("FAIL read_swap_clear: got %h exp %h", b2.uv_out, 8'h80); end
  endtask

  task automatic test_write_swap();
    checks++; if (b2.overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b exp 0", b2.overrun); end
    wr2(8'd30, 3'd6, 8'h80, 1'b0, 1'b1);
    checks++; if (b2.wr_bank !== 2'd0) begin errors++; $display("FAIL wr_swap_bank: got %0d exp 0", b2.wr_bank); end
    checks++; if (b2.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b exp 1", b2.overrun); end
    rd2(8'd30);
    checks++; if (b2.uv_out !== 8'h94) begin errors++; $display("FAIL wr_swap_data: got %h exp %h", b2.uv_out, 8'h94); end
    repeat (3) step();
    checks++; if (b2.overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b exp 1", b2.overrun); end
  endtask

  task automatic test_three_banks();
    logic [1:0] exp [3];
    exp[0] = 2'd1; exp[1] = 2'd2; exp[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      b3.swap = 1'b1;
      step();
      b3.swap = 1'b0;
      checks++; if (b3.wr_bank !== exp[i]) begin errors++; $display("FAIL rot3 step%0d: got %0d exp %0d", i, b3.wr_bank, exp[i]); end
    end
    checks++; if (b3.overrun !== 1'b0) begin errors++; $display("FAIL overrun3_pre: got %b exp 0", b3.overrun); end
    b3.wr_en = 1'b1; b3.wr_col = 8'd40; b3.wr_pal = 3'd7; b3.wr_pixels = 8'hC0; b3.swap = 1'b1;
    step();
    b3.wr_en = 1'b0; b3.swap = 1'b0;
    checks++; if (b3.overrun !== 1'b1) begin errors++; $display("FAIL overrun3_set: got %b exp 1", b3.overrun); end
    b3.rd_en = 1'b1; b3.rd_col = 8'd40;
    step();
    b3.rd_en = 1'b0;
    checks++; if (b3.uv_out !== 8'h98) begin errors++; $display("FAIL wr_swap3_data: got %h exp %h", b3.uv_out, 8'h98); end
  endtask

`ifdef MARIA_LBUF_COLLISION_EN
  task automatic test_collision();
    logic [7:0] pix  [8];
    logic       kang [8];
    logic       swp  [8];
    logic       exp  [8];
    pix[0] = 8'h40; kang[0] = 1'b0; swp[0] = 1'b0; exp[0] = 1'b0;
    pix[1] = 8'h80; kang[1] = 1'b0; swp[1] = 1'b0; exp[1] = 1'b1;
    pix[2] = 8'h00; kang[2] = 1'b0; swp[2] = 1'b1; exp[2] = 1'b0;
    pix[3] = 8'h80; kang[3] = 1'b0; swp[3] = 1'b0; exp[3] = 1'b0;
    pix[4] = 8'h00; kang[4] = 1'b0; swp[4] = 1'b0; exp[4] = 1'b0;
    pix[5] = 8'h00; kang[5] = 1'b1; swp[5] = 1'b0; exp[5] = 1'b0;
    pix[6] = 8'h40; kang[6] = 1'b0; swp[6] = 1'b0; exp[6] = 1'b0;
    pix[7] = 8'h80; kang[7] = 1'b0; swp[7] = 1'b1; exp[7] = 1'b1;
    checks++; if (coll2 !== 1'b0) begin errors++; $display("FAIL coll_pre: got %b exp 0", coll2); end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) swap2();
      else wr2(8'd5, 3'd0, pix[i], kang[i], swp[i]);
      checks++; if (coll2 !== exp[i]) begin errors++; $display("FAIL coll step%0d: got %b exp %b", i, coll2, exp[i]); end
    end
    swap2();
    checks++; if (coll2 !== 1'b0) begin errors++; $display("FAIL coll_swap_clear: got %b exp 0", coll2); end
  endtask
`endif

  task automatic test_reset_mid();
    swap2();
    wr2(8'd50, 3'd1, 8'h40, 1'b0, 1'b0);
    b2.rd_en = 1'b1; b2.rd_col = 8'd50;
    step();
    #2;
    reset_b = 1'b0;
    #1;
    checks++; if (b2.uv_out !== 8'h00) begin errors++; $display("FAIL midreset_uv: got %h exp %h", b2.uv_out, 8'h00); end
    checks++; if (b2.wr_bank !== 2'd0) begin errors++; $display("FAIL midreset_bank: got %0d exp 0", b2.wr_bank); end
    checks++; if (b2.overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun: got %b exp 0", b2.overrun); end
    checks++; if (b3.overrun !== 1'b0) begin errors++; $display("FAIL midreset_overrun3: got %b exp 0", b3.overrun); end
    b2.rd_en = 1'b0;
    @(negedge sysclk);
    reset_b = 1'b1;
    rd2(8'd50);
    checks++; if (b2.uv_out !== 8'h80) begin errors++; $display("FAIL midreset_bank1: got %h exp %h", b2.uv_out, 8'h80); end
    swap2();
    rd2(8'd50);
    checks++; if (b2.uv_out !== 8'h80) begin errors++; $display("FAIL midreset_bank0: got %h exp %h", b2.uv_out, 8'h80); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 25; i++) cmap[i] = 8'h80 + 8'(i);
    cmap[8] = 8'h4A;
    reset_b = 1'b0;
    b2.wr_en = 1'b0; b2.wr_col = '0; b2.wr_pal = '0; b2.wr_pixels = '0;
    b2.kangaroo = 1'b0; b2.swap = 1'b0; b2.rd_en = 1'b0; b2.rd_col = '0;
    b3.wr_en = 1'b0; b3.wr_col = '0; b3.wr_pal = '0; b3.wr_pixels = '0;
    b3.kangaroo = 1'b0; b3.swap = 1'b0; b3.rd_en = 1'b0; b3.rd_col = '0;
    repeat (2) step();
    test_reset();
    test_write_read();
    test_kangaroo();
    test_clip();
    test_read_swap();
    test_write_swap();
    test_three_banks();
`ifdef MARIA_LBUF_COLLISION_EN
    test_collision();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
